// File: rtl/syscall_pkg.sv
// Shared syscall codes, request payload, UART transmitter states and the baud divisor helper.
package syscall_pkg;

    localparam logic [7:0] SYSCALL_EXIT     = 8'h01;
    localparam logic [7:0] SYSCALL_PUTCHAR  = 8'h03;
    localparam logic [7:0] SYSCALL_PUTFLOAT = 8'h04;

    typedef struct packed {
        logic [7:0]  code;
        logic [31:0] arg;
    } syscall_req_t;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;

    // Clock cycles per UART bit, truncated.
    function automatic int unsigned baud_div(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/byte_fifo_4w.sv
// Byte FIFO taking 1-4 little-endian bytes per write and returning one byte per read.
module byte_fifo_4w #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [2:0]               wr_cnt,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(wr_cnt);
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < wr_cnt) begin
                    mem[wr_ptr[AW-1:0] + AW'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/syscall_uart_bridge.sv
// Turns tohost syscall strobes into 8N1 UART console output and reports exit once output has drained.
module syscall_uart_bridge
    import syscall_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          syscall_valid,
    input  logic [7:0]                    syscall_code,
    input  logic [31:0]                   syscall_arg,
    output logic                          syscall_ready,
    output logic                          uart_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          exit_valid,
    output logic [31:0]                   exit_code
);

    localparam int unsigned DIV = baud_div(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CW  = $clog2(DIV + 1);
    localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;

    syscall_req_t   req;
    logic           accept;
    logic           push;
    logic [2:0]     push_cnt;
    logic           pop;
    logic [7:0]     pop_data;
    logic           fifo_full;
    logic           fifo_empty;
    logic           exit_pending;

    uart_tx_state_e state_q, state_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_d;
    logic           bit_done;

    assign req           = '{code: syscall_code, arg: syscall_arg};
    assign syscall_ready = !exit_pending && !fifo_full && (fifo_level <= LW'(FIFO_DEPTH - 4));
    assign accept        = syscall_valid && syscall_ready;

    // Accepted print strobes become 1- or 4-byte FIFO writes; other codes write nothing.
    always_comb begin
        push     = 1'b0;
        push_cnt = 3'd0;
        if (accept) begin
            if (req.code == SYSCALL_PUTCHAR) begin
                push     = 1'b1;
                push_cnt = 3'd1;
            end else if (req.code == SYSCALL_PUTFLOAT) begin
                push     = 1'b1;
                push_cnt = 3'd4;
            end
        end
    end

    byte_fifo_4w #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push),
        .wr_cnt  (push_cnt),
        .wr_data (req.arg),
        .rd_en   (pop),
        .rd_data (pop_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Exit bookkeeping, sticky status flags and registered busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exit_pending <= 1'b0;
            exit_code    <= '0;
            overflow     <= 1'b0;
            exit_valid   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (accept && req.code == SYSCALL_EXIT) begin
                exit_pending <= 1'b1;
                exit_code    <= req.arg;
            end
            if (syscall_valid && !syscall_ready) begin
                overflow <= 1'b1;
            end
            if (exit_pending && fifo_empty && state_q == IDLE) begin
                exit_valid <= 1'b1;
            end
            busy <= !fifo_empty || (state_q != IDLE);
        end
    end

    assign bit_done = (baud_q == CW'(DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            uart_txd <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            uart_txd <= txd_d;
        end
    end

    // Line level is registered from the current state, so txd trails the state by one cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = pop_data;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (bit_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_syscall_uart_bridge.sv
// Randomized bench for syscall_uart_bridge: a frame-level timing model plus a UART line decoder.
`timescale 1ns/1ps
module tb_syscall_uart_bridge;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 90_000;
    localparam int unsigned DEPTH  = 16;
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int FRAME = 10 * DIV;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          syscall_valid = 1'b0;
    logic [7:0]    syscall_code = 8'h00;
    logic [31:0]   syscall_arg = 32'h0;
    logic          syscall_ready;
    logic          uart_txd;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          exit_valid;
    logic [31:0]   exit_code;

    syscall_uart_bridge #(
        .CLOCK_FREQ (CLK_HZ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .syscall_valid (syscall_valid),
        .syscall_code  (syscall_code),
        .syscall_arg   (syscall_arg),
        .syscall_ready (syscall_ready),
        .uart_txd      (uart_txd),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .exit_valid    (exit_valid),
        .exit_code     (exit_code)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: byte count, edge at which the transmitter can next pop, sticky flags.
    int          m_level = 0;
    longint      m_next_pop = 0;
    bit          m_pend = 0, m_ovf = 0, m_exv = 0, m_busy = 0;
    logic [31:0] m_code = 32'h0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    longint      rx_t[$];

    // Line decoder: samples mid-bit, abandons a frame whenever reset is low.
    initial begin : uart_monitor
        bit         active;
        bit         prev;
        int         n;
        int         idx;
        logic [7:0] sh;
        longint     t0;
        active = 1'b0; prev = 1'b1; n = 0; sh = 8'h00; t0 = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (prev && !uart_txd) begin
                    active = 1'b1; n = 0; t0 = cyc;
                end
            end else begin
                n++;
                if (n >= DIV / 2 && (n - DIV / 2) % DIV == 0) begin
                    idx = (n - DIV / 2) / DIV;
                    if (idx == 0) begin
                        checks++;
                        if (uart_txd !== 1'b0) begin
                            errors++;
                            $display("FAIL uart_start_bit: txd %b mid start bit at cyc %0d, required 0", uart_txd, cyc);
                            active = 1'b0;
                        end
                    end else if (idx <= 8) begin
                        sh[idx-1] = uart_txd;
                    end else begin
                        checks++;
                        if (uart_txd !== 1'b1) begin
                            errors++;
                            $display("FAIL uart_stop_bit: txd %b mid stop bit at cyc %0d, required 1", uart_txd, cyc);
                        end else begin
                            rx_q.push_back(sh);
                            rx_t.push_back(t0);
                        end
                        active = 1'b0;
                    end
                end
            end
            prev = uart_txd;
        end
    end

    initial begin : watchdog
        #800_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d, required completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    // Drive one clock of stimulus and advance the model across that edge.
    task automatic tick(input logic v, input logic [7:0] c, input logic [31:0] a);
        longint e;
        bit     rdy;
        bit     idle;
        e = cyc + 1;
        syscall_valid = v; syscall_code = c; syscall_arg = a;
        rdy  = !m_pend && (int'(DEPTH) - m_level >= 4);
        idle = (e >= m_next_pop);
        if (m_pend && m_level == 0 && idle) m_exv = 1'b1;
        m_busy = (m_level > 0) || !idle;
        if (m_level > 0 && idle) begin
            m_level--;
            m_next_pop = e + FRAME + 1;
        end
        if (v && !rdy) begin
            m_ovf = 1'b1;
        end else if (v) begin
            if (c == 8'h03) begin
                exp_q.push_back(a[7:0]);
                m_level += 1;
            end else if (c == 8'h04) begin
                for (int i = 0; i < 4; i++) exp_q.push_back(8'(a >> (8 * i)));
                m_level += 4;
            end else if (c == 8'h01) begin
                m_pend = 1'b1;
                m_code = a;
            end
        end
        @(posedge clock);
        @(negedge clock);
        syscall_valid = 1'b0;
    endtask

    // Idle until the model has drained; reports per-cycle disagreements and edge timings.
    task automatic run_drain(output int bad, output string why, output longint busy_fall, output longint exv_rise);
        bit prev_busy;
        bit prev_exv;
        bad = 0; why = ""; busy_fall = -1; exv_rise = -1;
        prev_busy = busy; prev_exv = exit_valid;
        for (int k = 0; k < 40 * FRAME; k++) begin
            tick(1'b0, 8'h00, 32'h0);
            if (fifo_level !== LW'(m_level) || busy !== m_busy || overflow !== m_ovf ||
                exit_valid !== m_exv || exit_code !== m_code ||
                syscall_ready !== (!m_pend && (int'(DEPTH) - m_level >= 4))) begin
                if (bad == 0)
                    $sformat(why, "cyc %0d level %0d/%0d busy %b/%b ovf %b/%b exv %b/%b ready %b",
                             cyc, fifo_level, m_level, busy, m_busy, overflow, m_ovf, exit_valid, m_exv, syscall_ready);
                bad++;
            end
            if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc;
            if (!prev_exv && exit_valid && exv_rise < 0) exv_rise = cyc;
            prev_busy = busy; prev_exv = exit_valid;
            if (m_level == 0 && !m_busy) break;
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_next_pop = 0; m_pend = 0; m_ovf = 0; m_exv = 0; m_busy = 0; m_code = 32'h0;
        exp_q.delete(); rx_q.delete(); rx_t.delete();
    endtask

    task automatic assert_reset();
        #2 reset = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clock);
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", uart_txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        checks++; if (exit_valid !== 1'b0) begin errors++; $display("FAIL reset_exit_valid: got %b required 0", exit_valid); end
        checks++; if (exit_code !== 32'h0) begin errors++; $display("FAIL reset_exit_code: got %h required 0", exit_code); end
        checks++; if (syscall_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", syscall_ready); end
        release_reset();
    endtask

    task automatic test_putchar();
        longint a, fall, rise;
        int     bad;
        string  why;
        a = cyc + 1;
        tick(1'b1, 8'h03, 32'h0000_0041);
        run_drain(bad, why, fall, rise);
        checks++; if (bad != 0) begin errors++; $display("FAIL putchar_cycles: %0d bad cycles, first %s", bad, why); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin errors++; $display("FAIL putchar_byte: got %0d bytes first %h required 1 byte 41", rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx); end
        checks++; if (rx_t.size() == 0 || rx_t[0] != a + 2) begin errors++; $display("FAIL putchar_start_edge: got %0d required %0d", rx_t.size() ? rx_t[0] : -1, a + 2); end
        checks++; if (fall != a + FRAME + 2) begin errors++; $display("FAIL putchar_busy_fall: got %0d required %0d", fall, a + FRAME + 2); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL putchar_level: got %0d required 0", fifo_level); end
        model_reset();
    endtask

    task automatic test_putfloat();
        logic [7:0] want [4];
        longint     a, fall, rise;
        int         bad;
        string      why;
        want = '{8'h00, 8'h00, 8'h80, 8'h3F};
        a = cyc + 1;
        tick(1'b1, 8'h04, 32'h3F80_0000);
        run_drain(bad, why, fall, rise);
        checks++; if (bad != 0) begin errors++; $display("FAIL putfloat_cycles: %0d bad cycles, first %s", bad, why); end
        checks++;
        if (rx_q.size() != 4) begin
            errors++; $display("FAIL putfloat_count: got %0d bytes required 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[i] !== want[i]) begin errors++; $display("FAIL putfloat_byte%0d: got %h required %h", i, rx_q[i], want[i]); end
                if (i > 0) begin
                    checks++;
                    if (rx_t[i] - rx_t[i-1] != FRAME + 1) begin errors++; $display("FAIL putfloat_spacing%0d: got %0d required %0d", i, rx_t[i] - rx_t[i-1], FRAME + 1); end
                end
            end
        end
        checks++; if (fall != a + 4 * (FRAME + 1) + 1) begin errors++; $display("FAIL putfloat_busy_fall: got %0d required %0d", fall, a + 4 * (FRAME + 1) + 1); end
        model_reset();
    endtask

    task automatic test_unknown();
        logic [7:0] codes [4];
        codes = '{8'h02, 8'h00, 8'h05, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, codes[i], $urandom);
            checks++; if (fifo_level !== '0) begin errors++; $display("FAIL unknown_level code %h: got %0d required 0", codes[i], fifo_level); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL unknown_overflow code %h: got %b required 0", codes[i], overflow); end
            checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL unknown_txd code %h: got %b required 1", codes[i], uart_txd); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unknown_busy code %h: got %b required 0", codes[i], busy); end
        end
        repeat (3) tick(1'b0, 8'h00, 32'h0);
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL unknown_rx: got %0d bytes required 0", rx_q.size()); end
        model_reset();
    endtask

    task automatic test_overflow();
        longint fall, rise;
        int     bad;
        string  why;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 8'h04, $urandom);
            if (i == 3) begin
                checks++; if (fifo_level !== LW'(15)) begin errors++; $display("FAIL overflow_level: got %0d required 15", fifo_level); end
                checks++; if (syscall_ready !== 1'b0) begin errors++; $display("FAIL overflow_ready: got %b required 0", syscall_ready); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_early: got %b required 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b required 1", overflow); end
        run_drain(bad, why, fall, rise);
        checks++; if (bad != 0) begin errors++; $display("FAIL overflow_cycles: %0d bad cycles, first %s", bad, why); end
        checks++;
        if (rx_q.size() != 16) begin
            errors++; $display("FAIL overflow_count: got %0d bytes required 16", rx_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL overflow_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
            end
        end
        assert_reset();
        release_reset();
    endtask

    task automatic test_random();
        longint     fall, rise;
        int         bad, sel, nbad;
        string      why;
        logic [7:0] c;
        for (int n = 0; n < 16; n++) begin
            sel = $urandom_range(0, 9);
            c = (sel < 5) ? 8'h03 : (sel < 8) ? 8'h04 : 8'($urandom_range(5, 255));
            tick(1'b1, c, $urandom);
            checks++;
            if (fifo_level !== LW'(m_level) || overflow !== m_ovf) begin
                errors++; $display("FAIL random_step%0d: level %0d ovf %b required level %0d ovf %b", n, fifo_level, overflow, m_level, m_ovf);
            end
            repeat ($urandom_range(0, 2)) tick(1'b0, 8'h00, 32'h0);
        end
        run_drain(bad, why, fall, rise);
        checks++; if (bad != 0) begin errors++; $display("FAIL random_cycles: %0d bad cycles, first %s", bad, why); end
        checks++;
        nbad = 0;
        if (rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d bytes required %0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) nbad++;
            checks++;
            if (nbad != 0) begin errors++; $display("FAIL random_bytes: %0d bytes differ, required 0", nbad); end
        end
        assert_reset();
        release_reset();
    endtask

    task automatic test_exit();
        longint fall, rise;
        int     bad;
        string  why;
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h03, $urandom);
        tick(1'b1, 8'h01, 32'd7);
        checks++; if (syscall_ready !== 1'b0) begin errors++; $display("FAIL exit_ready: got %b required 0", syscall_ready); end
        checks++; if (exit_valid !== 1'b0) begin errors++; $display("FAIL exit_early: got %b required 0", exit_valid); end
        run_drain(bad, why, fall, rise);
        checks++; if (bad != 0) begin errors++; $display("FAIL exit_cycles: %0d bad cycles, first %s", bad, why); end
        checks++; if (rise < 0 || rise != fall) begin errors++; $display("FAIL exit_rise_edge: got %0d required %0d", rise, fall); end
        checks++; if (exit_valid !== 1'b1) begin errors++; $display("FAIL exit_valid: got %b required 1", exit_valid); end
        checks++; if (exit_code !== 32'd7) begin errors++; $display("FAIL exit_code: got %0d required 7", exit_code); end
        checks++;
        if (rx_q.size() != 3 || rx_q[0] !== exp_q[0] || rx_q[1] !== exp_q[1] || rx_q[2] !== exp_q[2]) begin
            errors++; $display("FAIL exit_bytes: got %0d bytes required 3 matching", rx_q.size());
        end
        tick(1'b1, 8'h03, 32'h5A);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL exit_late_overflow: got %b required 1", overflow); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL exit_late_level: got %0d required 0", fifo_level); end
        assert_reset();
        release_reset();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        longint     a, fall, rise;
        int         bad;
        string      why;
        b = 8'($urandom) & 8'hF7;
        a = cyc + 1;
        tick(1'b1, 8'h03, {24'h0, b});
        while (cyc < a + 2 + 4 * DIV + DIV / 2) tick(1'b0, 8'h00, 32'h0);
        checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL midframe_bit3: got %b required 0", uart_txd); end
        assert_reset();
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL midframe_txd: got %b required 1", uart_txd); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL midframe_level: got %0d required 0", fifo_level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midframe_busy: got %b required 0", busy); end
        release_reset();
        tick(1'b1, 8'h03, 32'h55);
        run_drain(bad, why, fall, rise);
        checks++; if (bad != 0) begin errors++; $display("FAIL midframe_cycles: %0d bad cycles, first %s", bad, why); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin errors++; $display("FAIL midframe_after: got %0d bytes first %h required 1 byte 55", rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx); end
        model_reset();
    endtask

    initial begin
        test_reset();
        test_putchar();
        test_putfloat();
        test_unknown();
        test_overflow();
        test_random();
        test_exit();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
